deque_cmd_ctrl: RTL and testbench

//  Host-facing command front-end that sits directly upstream of the dual deque.
//  - Synchronises an asynchronous pin strobe and decodes a 2-bit opcode.
//  - Issues exactly one single-cycle push/pop per strobe, gated by the selected deque's full/empty flags.
//  - Captures popped data into a held output register; reports overflow/underflow.

---
 rtl/deque_cmd_ctrl.sv | 152 +++++++++++++++
 tb/tb_deque_cmd_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/deque_cmd_ctrl.sv
// Host command front-end for the dual deque: synchronises the strobe, decodes the opcode and
// issues one gated push/pop per strobe. Optional macro DEQUE_CTRL_PEEK_EN makes op 11 a PEEK.
module deque_cmd_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_STICKY  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe_in,
    input  logic [1:0] op_in,
    input  logic       dsel_in,
    input  logic       esel_in,
    input  logic [7:0] wdata_in,
    output logic       deque_select,
    output logic       end_select,
    output logic       push,
    output logic       pop,
    output logic [7:0] deque_wdata,
    input  logic       d0_empty,
    input  logic       d0_full,
    input  logic       d1_empty,
    input  logic       d1_full,
    input  logic [7:0] deque_rdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       err_overflow,
    output logic       err_underflow
);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ISSUE, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_PEEK = 2'b11} op_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s, w_rise, w_full, w_empty, w_ack;
    op_t                    r_op;
    logic                   r_dsel, r_esel;
    logic [7:0]             r_wdata, r_rdata;
    logic                   r_push, r_pop, r_peek, r_nop, r_rej_ovf, r_rej_unf;
    logic                   r_err_ovf, r_err_unf;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_s & ~r_s_d;
    assign w_full  = r_dsel ? d1_full  : d0_full;
    assign w_empty = r_dsel ? d1_empty : d0_empty;

    // NOTE: every flop below uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_s_d   <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], strobe_in};
            r_s_d   <= w_s;
            r_state <= w_state_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_DONE;
            S_DONE: begin
                w_ack = 1'b1;
                if (!w_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_NOP;
            r_dsel    <= 1'b0;
            r_esel    <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_peek    <= 1'b0;
            r_nop     <= 1'b0;
            r_rej_ovf <= 1'b0;
            r_rej_unf <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            // Decision flags live for the single ISSUE cycle only.
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_peek    <= 1'b0;
            r_nop     <= 1'b0;
            r_rej_ovf <= 1'b0;
            r_rej_unf <= 1'b0;
            unique case (r_state)
                S_IDLE: if (w_rise) begin
                    r_op    <= op_t'(op_in);
                    r_dsel  <= dsel_in;
                    r_esel  <= esel_in;
                    r_wdata <= wdata_in;
                end
                S_LATCH: begin
                    unique case (r_op)
                        OP_NOP:  r_nop <= 1'b1;
                        OP_PUSH: if (w_full) r_rej_ovf <= 1'b1; else r_push <= 1'b1;
                        OP_POP:  if (w_empty) r_rej_unf <= 1'b1; else r_pop <= 1'b1;
                        OP_PEEK: begin
`ifdef DEQUE_CTRL_PEEK_EN
                            if (w_empty) r_rej_unf <= 1'b1; else r_peek <= 1'b1;
`else
                            r_rej_ovf <= 1'b1;
                            r_rej_unf <= 1'b1;
`endif
                        end
                        default: r_nop <= 1'b1;
                    endcase
                end
                S_ISSUE: begin
                    // deque_rdata is still the pre-pop head during this cycle.
                    if (r_pop || r_peek) r_rdata <= deque_rdata;
                    if (r_nop) begin
                        r_err_ovf <= 1'b0;
                        r_err_unf <= 1'b0;
                    end else if (r_rej_ovf || r_rej_unf) begin
                        if (r_rej_ovf) r_err_ovf <= 1'b1;
                        if (r_rej_unf) r_err_unf <= 1'b1;
                    end else if (ERR_STICKY == 0) begin
                        r_err_ovf <= 1'b0;
                        r_err_unf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign deque_select  = r_dsel;
    assign end_select    = r_esel;
    assign deque_wdata   = r_wdata;
    assign push          = r_push;
    assign pop           = r_pop;
    assign rdata         = r_rdata;
    assign ack           = w_ack;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

endmodule

// File: tb/tb_deque_cmd_ctrl.sv
// Scoreboard bench for deque_cmd_ctrl with a behavioural 16-deep dual deque downstream.
// Honours DEQUE_CTRL_PEEK_EN the same way the design does.
module tb_deque_cmd_ctrl;

    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strobe_in;
    logic [1:0] op_in;
    logic       dsel_in, esel_in;
    logic [7:0] wdata_in;
    logic       deque_select, end_select, push, pop;
    logic [7:0] deque_wdata, deque_rdata, rdata;
    logic       d0_empty, d0_full, d1_empty, d1_full;
    logic       ack, err_overflow, err_underflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    deque_cmd_ctrl #(.SYNC_STAGES(SYNC_STAGES), .ERR_STICKY(1)) dut (
        .clk(clk), .rst_n(rst_n), .strobe_in(strobe_in), .op_in(op_in),
        .dsel_in(dsel_in), .esel_in(esel_in), .wdata_in(wdata_in),
        .deque_select(deque_select), .end_select(end_select), .push(push), .pop(pop),
        .deque_wdata(deque_wdata), .d0_empty(d0_empty), .d0_full(d0_full),
        .d1_empty(d1_empty), .d1_full(d1_full), .deque_rdata(deque_rdata),
        .rdata(rdata), .ack(ack), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic q, input logic [7:0] w,
                                input logic [7:0] r, input logic o, input logic u);
        exp_t e;
        e.push = p; e.pop = q; e.wdata = w; e.rdata = r; e.ovf = o; e.unf = u;
        return e;
    endfunction

    // Downstream dual deque: ring buffers, end 0 = front, end 1 = back.
    logic [7:0] m_mem  [2][16];
    logic [3:0] m_head [2] = '{default: 4'd0};
    logic [4:0] m_cnt  [2] = '{default: 5'd0};
    logic [3:0] w_back_idx;

    assign w_back_idx  = m_head[deque_select] + m_cnt[deque_select][3:0] - 4'd1;
    assign deque_rdata = end_select ? m_mem[deque_select][w_back_idx]
                                    : m_mem[deque_select][m_head[deque_select]];
    assign d0_empty = (m_cnt[0] == 5'd0);
    assign d1_empty = (m_cnt[1] == 5'd0);
    assign d0_full  = (m_cnt[0] == 5'd16);
    assign d1_full  = (m_cnt[1] == 5'd16);

    always @(posedge clk) begin
        if (push) begin
            check("push_not_full", deque_select ? d1_full : d0_full, 0);
            if (end_select) begin
                m_mem[deque_select][m_head[deque_select] + m_cnt[deque_select][3:0]] <= deque_wdata;
            end else begin
                m_mem[deque_select][m_head[deque_select] - 4'd1] <= deque_wdata;
                m_head[deque_select] <= m_head[deque_select] - 4'd1;
            end
            m_cnt[deque_select] <= m_cnt[deque_select] + 5'd1;
        end else if (pop) begin
            check("pop_not_empty", deque_select ? d1_empty : d0_empty, 0);
            if (!end_select) m_head[deque_select] <= m_head[deque_select] + 4'd1;
            m_cnt[deque_select] <= m_cnt[deque_select] - 5'd1;
        end
    end

    // Monitor: counts pulses per command and scores each rising ack against the queue.
    int         n_push = 0, n_pop = 0;
    logic       prev_ack = 1'b0, prev_push = 1'b0, prev_pop = 1'b0;
    logic [7:0] wdata_at_push = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_push = 0; n_pop = 0;
            prev_ack = 1'b0; prev_push = 1'b0; prev_pop = 1'b0;
        end else begin
            if (push || pop) check("push_pop_exclusive", {31'd0, push & pop}, 0);
            if (push) begin n_push++; wdata_at_push = deque_wdata; end
            if (pop) n_pop++;
            if (ack && !prev_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("push_count", n_push, {31'd0, e.push});
                    check("pop_count", n_pop, {31'd0, e.pop});
                    check("push_before_ack", prev_push, e.push);
                    check("pop_before_ack", prev_pop, e.pop);
                    if (e.push) check("deque_wdata", wdata_at_push, e.wdata);
                    check("rdata", rdata, e.rdata);
                    check("err_overflow", err_overflow, e.ovf);
                    check("err_underflow", err_underflow, e.unf);
                end
                n_push = 0; n_pop = 0;
            end
            prev_ack = ack; prev_push = push; prev_pop = pop;
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic ds, input logic es,
                          input logic [7:0] wd, input exp_t e);
        int lat;
        exp_q.push_back(e);
        @(negedge clk);
        op_in = op; dsel_in = ds; esel_in = es; wdata_in = wd;
        strobe_in = 1'b1;
        lat = 0;
        while (!ack && lat < 40) begin @(negedge clk); lat++; end
        check("ack_latency", lat, SYNC_STAGES + 3);
        strobe_in = 1'b0;
        lat = 0;
        while (ack && lat < 40) begin @(negedge clk); lat++; end
        check("ack_release", ack, 0);
    endtask

    initial begin
        int wait_n;
        rst_n = 1'b0; strobe_in = 1'b0; op_in = 2'b00;
        dsel_in = 1'b0; esel_in = 1'b0; wdata_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_push", push, 0);
        check("rst_pop", pop, 0);
        check("rst_rdata", rdata, 0);
        check("rst_errs", {err_overflow, err_underflow}, 0);
        rst_n = 1'b1;

        // Reset while the push pulse is on the wire.
        @(negedge clk);
        op_in = 2'b01; dsel_in = 1'b1; esel_in = 1'b1; wdata_in = 8'h77; strobe_in = 1'b1;
        wait_n = 0;
        while (!push && wait_n < 20) begin @(negedge clk); wait_n++; end
        check("rst_mid_push_seen", push, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_push", push, 0);
        check("rst_mid_pop", pop, 0);
        check("rst_mid_ack", ack, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_errs", {err_overflow, err_underflow}, 0);
        check("rst_mid_latches", {deque_select, end_select, deque_wdata}, 0);
        strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_after_rst", {ack, push, pop}, 0);
        check("no_partial_push", m_cnt[1], 0);

        do_cmd(2'b01, 1'b0, 1'b0, 8'hA5, mk(1, 0, 8'hA5, 8'h00, 0, 0));
        do_cmd(2'b10, 1'b0, 1'b0, 8'h00, mk(0, 1, 8'h00, 8'hA5, 0, 0));
        check("d0_empty_after_pop", d0_empty, 1);

        do_cmd(2'b10, 1'b1, 1'b0, 8'h00, mk(0, 0, 8'h00, 8'hA5, 0, 1));
        do_cmd(2'b00, 1'b0, 1'b0, 8'h00, mk(0, 0, 8'h00, 8'hA5, 0, 0));

        for (int i = 0; i < 16; i++)
            do_cmd(2'b01, 1'b0, 1'b1, 8'h10 + 8'(i), mk(1, 0, 8'h10 + 8'(i), 8'hA5, 0, 0));
        do_cmd(2'b01, 1'b0, 1'b1, 8'hEE, mk(0, 0, 8'h00, 8'hA5, 1, 0));
        check("d0_full_kept", d0_full, 1);
        do_cmd(2'b10, 1'b1, 1'b0, 8'h00, mk(0, 0, 8'h00, 8'hA5, 1, 1));
        do_cmd(2'b10, 1'b0, 1'b0, 8'h00, mk(0, 1, 8'h00, 8'h10, 1, 1));
        do_cmd(2'b10, 1'b0, 1'b1, 8'h00, mk(0, 1, 8'h00, 8'h1F, 1, 1));
        do_cmd(2'b00, 1'b0, 1'b0, 8'h00, mk(0, 0, 8'h00, 8'h1F, 0, 0));

        do_cmd(2'b01, 1'b0, 1'b0, 8'h3C, mk(1, 0, 8'h3C, 8'h1F, 0, 0));
`ifdef DEQUE_CTRL_PEEK_EN
        do_cmd(2'b11, 1'b0, 1'b0, 8'h00, mk(0, 0, 8'h00, 8'h3C, 0, 0));
        do_cmd(2'b10, 1'b0, 1'b0, 8'h00, mk(0, 1, 8'h00, 8'h3C, 0, 0));
`else
        do_cmd(2'b11, 1'b0, 1'b0, 8'h00, mk(0, 0, 8'h00, 8'h1F, 1, 1));
        do_cmd(2'b10, 1'b0, 1'b0, 8'h00, mk(0, 1, 8'h00, 8'h3C, 1, 1));
`endif
        check("d0_count_end", m_cnt[0], 14);

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 50) begin @(negedge clk); wait_n++; end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
